// File: rtl/cpu_pkg.sv
// Shared definitions for the CPU control path and its program loader:
// loader state encoding, 3-bit opcodes and an instruction-byte builder.
package cpu_pkg;

  localparam int unsigned DATA_W = 8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RELEASE,
    S_RUN,
    S_HALTED,
    S_ERROR
  } loader_state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'd0,
    OP_SUB  = 3'd1,
    OP_AND  = 3'd2,
    OP_OR   = 3'd3,
    OP_LD   = 3'd4,
    OP_ST   = 3'd5,
    OP_JMP  = 3'd6,
    OP_HALT = 3'd7
  } opcode_t;

  // Instruction byte layout: opcode in the top three bits, operand below.
  function automatic logic [DATA_W-1:0] mk_instr(input opcode_t op, input logic [4:0] arg);
    return {op, arg};
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones; synchronous clear has priority over enable.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/program_loader.sv
// Streams program bytes into memory while the CPU is held in reset, then
// releases the CPU, counts its run cycles and reports halt or overflow.
module program_loader
  import cpu_pkg::*;
#(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_last,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_din,
  output logic              mem_we,
  output logic              mem_own,
  output logic              cpu_reset,
  input  logic              cpu_halt,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [ADDR_W:0]   load_count,
  output logic [CNT_W-1:0]  run_cycles
);

  loader_state_t     state, state_n;
  logic [ADDR_W-1:0] ptr;
  logic              accept;
  logic              load_start;
  logic              cpu_running;

  assign in_ready    = (state == S_LOAD);
  assign accept      = in_valid & in_ready;
  assign busy        = (state == S_LOAD) || (state == S_RELEASE);
  assign done        = (state == S_HALTED);
  assign err         = (state == S_ERROR);
  assign cpu_running = (state == S_RUN) || (state == S_HALTED);
  assign cpu_reset   = !cpu_running;
  assign mem_own     = !cpu_running;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n    = state;
    load_start = 1'b0;
    case (state)
      S_IDLE, S_HALTED, S_ERROR: begin
        if (start) begin
          state_n    = S_LOAD;
          load_start = 1'b1;
        end
      end
      S_LOAD: begin
        // in_last on the final slot is a clean fit, so it is tested first.
        if (accept) begin
          if (in_last) begin
            state_n = S_RELEASE;
          end else if (&ptr) begin
            state_n = S_ERROR;
          end
        end
      end
      S_RELEASE: state_n = S_RUN;
      S_RUN: begin
        if (start) begin
          state_n    = S_LOAD;
          load_start = 1'b1;
        end else if (cpu_halt) begin
          state_n = S_HALTED;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Write port is registered: the byte accepted on one edge is presented the
  // next cycle, which is why RELEASE exists to let the final write land.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr        <= '0;
      load_count <= '0;
      mem_addr   <= '0;
      mem_din    <= '0;
      mem_we     <= 1'b0;
    end else begin
      mem_we <= accept;
      if (load_start) begin
        ptr        <= '0;
        load_count <= '0;
      end else if (accept) begin
        mem_addr   <= ptr;
        mem_din    <= in_data;
        ptr        <= ptr + 1'b1;
        load_count <= load_count + 1'b1;
      end
    end
  end

  sat_counter #(
    .W(CNT_W)
  ) u_run_cnt (
    .clk    (clk),
    .reset_n(reset_n),
    .clr    (load_start),
    .en     (state == S_RUN),
    .count  (run_cycles)
  );

endmodule

// File: tb/tb_program_loader.sv
// Directed sequence with randomized bytes and handshake gaps for program_loader,
// checked against a write-log / counter reference model.
module tb_program_loader;
  import cpu_pkg::*;

  localparam int unsigned ADDR_W = 4;
  localparam int unsigned CNT_W  = 5;
  localparam int          CMAX   = (1 << CNT_W) - 1;

  logic              clk = 1'b0;
  logic              reset_n;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_last;
  logic              in_ready;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_din;
  logic              mem_we;
  logic              mem_own;
  logic              cpu_reset;
  logic              cpu_halt;
  logic              busy;
  logic              done;
  logic              err;
  logic [ADDR_W:0]   load_count;
  logic [CNT_W-1:0]  run_cycles;

  int checks = 0;
  int errors = 0;
  int own_viol = 0;

  logic [ADDR_W+7:0] wr_log[$];
  logic [7:0]        stim[$];

  program_loader #(
    .ADDR_W(ADDR_W),
    .CNT_W (CNT_W)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .start     (start),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_last   (in_last),
    .in_ready  (in_ready),
    .mem_addr  (mem_addr),
    .mem_din   (mem_din),
    .mem_we    (mem_we),
    .mem_own   (mem_own),
    .cpu_reset (cpu_reset),
    .cpu_halt  (cpu_halt),
    .busy      (busy),
    .done      (done),
    .err       (err),
    .load_count(load_count),
    .run_cycles(run_cycles)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mem_we === 1'b1) begin
      wr_log.push_back({mem_addr, mem_din});
      if (mem_own !== 1'b1) own_viol++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int sat(input int v);
    return (v > CMAX) ? CMAX : v;
  endfunction

  task automatic fill_random(input int n);
    stim.delete();
    repeat (n) stim.push_back(8'($urandom));
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Offers stim[0..n-1] with random idle gaps; returns just after the final accept edge.
  task automatic load_bytes(input int n, input bit last, input int gap_lo, input int gap_hi,
                            input bit poke_start);
    wr_log.delete();
    for (int i = 0; i < n; i++) begin
      chk("in_ready_load", 32'(in_ready), 32'd1);
      in_valid = 1'b1;
      in_data  = stim[i];
      in_last  = last && (i == n - 1);
      start    = poke_start && (i == 1);
      tick();
      in_valid = 1'b0;
      in_last  = 1'b0;
      start    = 1'b0;
      in_data  = 8'($urandom);
      if (i != n - 1) repeat ($urandom_range(gap_hi, gap_lo)) tick();
    end
  endtask

  task automatic check_writes(input int n);
    chk("wr_count", 32'(wr_log.size()), 32'(n));
    for (int i = 0; i < n && i < wr_log.size(); i++) begin
      chk("wr_addr", 32'(wr_log[i][ADDR_W+7:8]), 32'(i));
      chk("wr_data", 32'(wr_log[i][7:0]), 32'(stim[i]));
    end
  endtask

  // Entered at the first RUN cycle; halts during RUN cycle k.
  task automatic run_and_halt(input int k);
    repeat (k - 1) tick();
    chk("run_pre_halt", 32'(run_cycles), 32'(sat(k - 1)));
    cpu_halt = 1'b1;
    tick();
    cpu_halt = 1'b0;
    chk("halt_done", 32'(done), 32'd1);
    chk("halt_run_cycles", 32'(run_cycles), 32'(sat(k)));
    repeat (3) tick();
    chk("halt_frozen", 32'(run_cycles), 32'(sat(k)));
    chk("halt_done_hold", 32'(done), 32'd1);
    chk("halt_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("halt_mem_own", 32'(mem_own), 32'd0);
  endtask

  task automatic check_load_entry(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd1);
    chk({tag, "_cpu_reset"}, 32'(cpu_reset), 32'd1);
    chk({tag, "_mem_own"}, 32'(mem_own), 32'd1);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_load_count"}, 32'(load_count), 32'd0);
    chk({tag, "_run_cycles"}, 32'(run_cycles), 32'd0);
  endtask

  initial begin
    reset_n  = 1'b0;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    in_last  = 1'b0;
    cpu_halt = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rst_mem_own", 32'(mem_own), 32'd1);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_load_count", 32'(load_count), 32'd0);
    chk("rst_run_cycles", 32'(run_cycles), 32'd0);
    reset_n = 1'b1;
    tick();

    // Bytes offered in IDLE must be ignored.
    in_valid = 1'b1;
    in_data  = 8'hAA;
    repeat (2) tick();
    in_valid = 1'b0;
    tick();
    chk("idle_no_write", 32'(wr_log.size()), 32'd0);
    chk("idle_load_count", 32'(load_count), 32'd0);

    // Three-instruction program; a stray start mid-load must be ignored.
    pulse_start();
    check_load_entry("t1_entry");
    chk("t1_busy", 32'(busy), 32'd1);
    stim.delete();
    stim.push_back(mk_instr(OP_OR, 5'd1));
    stim.push_back(mk_instr(OP_ADD, 5'd2));
    stim.push_back(mk_instr(OP_HALT, 5'd0));
    load_bytes(3, 1'b1, 0, 2, 1'b1);
    chk("rel_busy", 32'(busy), 32'd1);
    chk("rel_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("rel_in_ready", 32'(in_ready), 32'd0);
    chk("rel_mem_we", 32'(mem_we), 32'd1);
    chk("rel_mem_addr", 32'(mem_addr), 32'd2);
    chk("rel_mem_din", 32'(mem_din), 32'hE0);
    tick();
    chk("run_cpu_reset", 32'(cpu_reset), 32'd0);
    chk("run_mem_own", 32'(mem_own), 32'd0);
    chk("run_mem_we", 32'(mem_we), 32'd0);
    chk("run_busy", 32'(busy), 32'd0);
    chk("run_load_count", 32'(load_count), 32'd3);
    chk("run_cycles_start", 32'(run_cycles), 32'd0);
    check_writes(3);
    run_and_halt(10);

    pulse_start();
    check_load_entry("from_halt");

    // Backpressure: valid toggles 1,0,1.
    fill_random(2);
    load_bytes(2, 1'b1, 1, 1, 1'b0);
    chk("bp_release_busy", 32'(busy), 32'd1);
    tick();
    chk("bp_load_count", 32'(load_count), 32'd2);
    check_writes(2);

    // start wins over a simultaneous halt.
    repeat (2) tick();
    start    = 1'b1;
    cpu_halt = 1'b1;
    tick();
    start    = 1'b0;
    cpu_halt = 1'b0;
    check_load_entry("start_vs_halt");

    // Overflow: full memory without in_last.
    fill_random(16);
    load_bytes(16, 1'b0, 0, 2, 1'b0);
    chk("ovf_err", 32'(err), 32'd1);
    chk("ovf_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("ovf_mem_own", 32'(mem_own), 32'd1);
    chk("ovf_in_ready", 32'(in_ready), 32'd0);
    chk("ovf_busy", 32'(busy), 32'd0);
    chk("ovf_mem_we", 32'(mem_we), 32'd1);
    chk("ovf_mem_addr", 32'(mem_addr), 32'd15);
    chk("ovf_load_count", 32'(load_count), 32'd16);
    tick();
    in_valid = 1'b1;
    repeat (2) tick();
    in_valid = 1'b0;
    tick();
    chk("ovf_no_more_accept", 32'(load_count), 32'd16);
    chk("ovf_err_hold", 32'(err), 32'd1);
    check_writes(16);
    pulse_start();
    check_load_entry("from_err");

    // Exact fit, then a long run that saturates the cycle counter.
    fill_random(16);
    load_bytes(16, 1'b1, 0, 1, 1'b0);
    chk("fit_err", 32'(err), 32'd0);
    chk("fit_busy", 32'(busy), 32'd1);
    chk("fit_mem_addr", 32'(mem_addr), 32'd15);
    tick();
    chk("fit_load_count", 32'(load_count), 32'd16);
    chk("fit_cpu_reset", 32'(cpu_reset), 32'd0);
    check_writes(16);
    run_and_halt(int'($urandom_range(45, 30)));

    // Reset mid-load aborts immediately.
    pulse_start();
    fill_random(2);
    load_bytes(2, 1'b0, 0, 1, 1'b0);
    chk("mid_mem_we_before", 32'(mem_we), 32'd1);
    chk("mid_load_count_before", 32'(load_count), 32'd2);
    reset_n = 1'b0;
    #1;
    chk("mid_in_ready", 32'(in_ready), 32'd0);
    chk("mid_mem_we", 32'(mem_we), 32'd0);
    chk("mid_cpu_reset", 32'(cpu_reset), 32'd1);
    chk("mid_mem_own", 32'(mem_own), 32'd1);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_load_count", 32'(load_count), 32'd0);
    #5;
    reset_n = 1'b1;
    tick();
    chk("post_rst_idle", 32'(in_ready), 32'd0);

    chk("we_without_own", 32'(own_viol), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
